// File: rtl/fifo_rd_drain.sv
// -----------------------------------------------------------------------------
// fifo_rd_drain
//
// Read-side consumer for the async FIFO, living entirely in the read clock
// domain. Words are popped from the FIFO read port and re-presented as a
// registered valid/ready stream toward a NoC router input port. A two-entry
// skid buffer (e0 = head, e1 = second) decouples the pop strobe from the
// downstream ready, so rinc is a function of registered occupancy only.
//
// Ports
//   rclk       read-domain clock, rising edge
//   rrst       synchronous, active-high reset
//   rempty     FIFO empty flag; rdata valid whenever low
//   rdata      FIFO head word (combinational read)
//   rinc       FIFO pop strobe, one word per cycle high
//   en         drain enable; low blocks new pops immediately
//   out_data   stream data (skid buffer head, registered)
//   out_valid  stream valid (registered occupancy != 0)
//   out_ready  downstream accept
//   flit_cnt   accepted handshakes, modulo 2^CNTW
//   occ        skid buffer occupancy 0..2 (debug)
// -----------------------------------------------------------------------------
module fifo_rd_drain #(
  parameter int DSIZE = 32,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             en,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNTW-1:0]  flit_cnt,
  output logic [1:0]       occ
);

  logic [DSIZE-1:0] e0_q;
  logic [DSIZE-1:0] e0_d;
  logic [DSIZE-1:0] e1_q;
  logic             e1_load;
  logic [1:0]       occ_q;
  logic [1:0]       occ_d;
  logic [CNTW-1:0]  cnt_q;
  logic             push;
  logic             pop;

  // Pop decision looks only at registered occupancy; out_ready never reaches
  // rinc, which keeps the FIFO read path free of a downstream timing arc.
  assign push      = ~rrst & en & ~rempty & (occ_q < 2'd2);
  assign rinc      = push;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = e0_q;
  assign pop       = out_valid & out_ready;
  assign occ       = occ_q;
  assign flit_cnt  = cnt_q;

  always_comb begin
    // NOTE: every variable gets a hold value before the case so no path
    // leaves one unassigned; that is what keeps this block free of latches.
    occ_d   = occ_q;
    e0_d    = e0_q;
    e1_load = 1'b0;
    case (occ_q)
      2'd0: begin
        if (push) begin
          e0_d  = rdata;
          occ_d = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b10: begin
            e1_load = 1'b1;
            occ_d   = 2'd2;
          end
          2'b01: occ_d = 2'd0;
          // Head leaves and the new word replaces it directly.
          2'b11: e0_d  = rdata;
          default: ;
        endcase
      end
      2'd2: begin
        // Full: push is impossible here, only the head can move on.
        if (pop) begin
          e0_d  = e1_q;
          occ_d = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge rclk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rrst) begin
      occ_q <= 2'd0;
      e0_q  <= '0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      if (pop) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // NOTE: e1 is deliberately left without reset; it is only ever read at
  // occ=2, which can only be reached by loading it first.
  always_ff @(posedge rclk) begin
    if (e1_load) e1_q <= rdata;
  end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer for the async FIFO, sitting in the read clock domain.
- Pops words from the FIFO read port (rempty / rinc / rdata) and re-presents them as a registered valid/ready stream toward a NoC router input port.
- Holds up to 2 words in a skid buffer, so rinc never depends combinationally on downstream ready.
- Counts delivered flits for debug/statistics.

Parameters:
DSIZE, 32, data word width; must match the FIFO DSIZE.
CNTW, 16, width of the delivered-flit counter.

Ports:
rclk  input  1  read-domain clock; all logic is on its rising edge.
rrst  input  1  synchronous, active-high reset.
rempty  input  1  FIFO empty flag; rdata is valid whenever rempty is low.
rdata  input  DSIZE  FIFO head word; combinational read of the current read address.
rinc  output  1  FIFO pop strobe; one word is consumed per rclk cycle that rinc is high.
en  input  1  drain enable; when low, no new pops are issued.
out_data  output  DSIZE  stream data; this is the head of the skid buffer.
out_valid  output  1  stream valid.
out_ready  input  1  downstream accept.
flit_cnt  output  CNTW  number of accepted handshakes, modulo 2^CNTW.
occ  output  2  skid buffer occupancy (0..2), for debug.

Behaviour:
- Clock and reset: single clock rclk; rrst is synchronous and active-high.
- Reset values: occ=0, out_valid=0, out_data=0, flit_cnt=0.
- rinc is forced to 0 combinationally while rrst=1.
- Storage: two DSIZE registers, e0 (head) and e1, plus a 2-bit occupancy register.
- Outputs: out_valid = (occ != 0); out_data = e0. Both come straight from registers.
- pop = out_valid & out_ready.
- push = rinc = ~rrst & en & ~rempty & (occ < 2). This uses registered occ only, with no path from out_ready to rinc.
- rdata is sampled on the same edge at which rinc is high.
- Buffer update per edge (when not in reset):
  - occ0, push: e0 <= rdata; occ=1.
  - occ1, push only: e1 <= rdata; occ=2.
  - occ1, pop only: occ=0.
  - occ1, push and pop: e0 <= rdata; occ stays 1.
  - occ2, pop: e0 <= e1; occ=1. No push is possible at occ2.
  - No push and no pop: all registers hold.
- Latency: word present (rempty=0) in cycle t with occ=0 → rinc high in t → out_valid high in t+1 with out_data = that word.
- Throughput: 1 word/cycle sustained while out_ready=1 and the FIFO is non-empty, because occ stays at 1.
- Backpressure: with out_ready=0, at most 2 words are popped, then rinc=0 until a pop occurs.
- Hold rule: out_data and out_valid must hold stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO order; no word is duplicated or dropped outside of reset.
- en=0: rinc=0 immediately, in the same cycle. Buffered words continue to drain to the stream. Re-asserting en resumes popping in the same cycle.
- flit_cnt: increments by 1 on each pop and wraps from 2^CNTW-1 to 0.
- Reset mid-operation: buffered words (up to 2) are discarded and flit_cnt clears. Words already popped from the FIFO are lost. No rinc is issued in any reset cycle.

Test Plan:
1. Reset, then present one word 0xA5A50001 (rempty=0 for one pop) with out_ready=1, en=1 → rinc high for exactly 1 cycle; out_valid=1 the next cycle with out_data=0xA5A50001; flit_cnt=1; occ returns to 0.
2. Stream 8 words 0x10..0x17 with out_ready=1 → rinc high 8 consecutive cycles; out_valid high 8 consecutive cycles with in-order data; occ never exceeds 1; flit_cnt=8.
3. out_ready=0, FIFO holds 5 words → exactly 2 pops, then rinc=0; occ=2; out_data stable at word 0 for the whole stall. Then raise out_ready → remaining 5 words are delivered in order; flit_cnt=5.
4. Drop en while words are pending, out_ready=1 → rinc=0 in the same cycle; the buffered words drain; out_valid then falls with occ=0. Re-raise en → popping resumes immediately.
5. Assert rrst with occ=2 and the FIFO non-empty → the next cycle shows out_valid=0, occ=0, flit_cnt=0; rinc=0 for every cycle rrst=1.
6. Preload flit_cnt to 0xFFFF (CNTW=16) via 65535 handshakes, then one more handshake → flit_cnt=0x0000.
